spike_rate_encoder: RTL and testbench
=====================================

SPIKE_RATE_ENCODER -- requirements
Module: spike_rate_encoder

Interface
REQ-001 Parameter RATE_W, default 8, sets the width of the rate and phase accumulator.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 ena  input  1  design enable; low freezes all state.
REQ-005 cfg_rate  input  RATE_W  requested spike rate, in spikes per 2^RATE_W cycles.
REQ-006 cfg_valid  input  1  cfg_rate valid.
REQ-007 cfg_ready  output  1  encoder accepts cfg_rate this cycle.
REQ-008 burst_len  input  4  spikes per burst; 0 = continuous; sampled on start.
REQ-009 start  input  1  single-cycle request to begin encoding.
REQ-010 stop  input  1  single-cycle request to abort encoding.
REQ-011 spike_out  output  1  registered spike stream, drives a neuron spike input.
REQ-012 busy  output  1  high in RUN.
REQ-013 done  output  1  one-cycle pulse at burst completion.
REQ-014 spike_cnt  output  8  spikes emitted since last start, saturating at 255.

Function
REQ-015 States SHALL be IDLE, RUN and DONE.
REQ-016 IDLE->RUN on start; this clears acc, spike_cnt and spike_out, and latches burst_len.
REQ-017 In RUN with ena=1, each edge SHALL compute {carry,acc} <= acc + rate_reg and set spike_out <= carry.
REQ-018 First spike SHALL occur ceil(2^RATE_W / rate_reg) edges after RUN entry; rate 128 gives spike_out = 0,1,0,1...
REQ-019 rate_reg = 0 SHALL produce no spikes while RUN continues.
REQ-020 Each edge that sets spike_out=1 SHALL increment spike_cnt, saturating at 255.
REQ-021 If latched burst_len != 0, the edge producing spike number burst_len SHALL move state to DONE; spike_out is 1 during the DONE cycle.
REQ-022 DONE SHALL last exactly one cycle with done=1, then return to IDLE with spike_out=0.
REQ-023 Continuous mode (burst_len=0) SHALL stay in RUN until stop.
REQ-024 stop in RUN or DONE SHALL force IDLE on the next edge with spike_out=0; spike_cnt holds its value.
REQ-025 If start and stop are both high, stop wins; start in RUN or DONE SHALL be ignored.
REQ-026 cfg_ready SHALL be 0 in RUN when latched burst_len != 0, and 1 otherwise.
REQ-027 cfg_valid && cfg_ready SHALL load rate_reg on that edge; in continuous RUN the new rate takes effect at the next accumulation, and acc is not cleared.
REQ-028 With ena=0: state, acc, rate_reg and spike_cnt SHALL hold; spike_out SHALL be 0; start, stop and cfg loads are ignored.
REQ-029 busy and done SHALL be decoded from the registered state.

Reset
REQ-030 rst_n low SHALL asynchronously set state=IDLE, acc=0, rate_reg=0, spike_cnt=0, latched burst_len=0.
REQ-031 During reset, outputs SHALL be spike_out=0, busy=0, done=0 and cfg_ready=1.
REQ-032 A reset asserted mid-RUN or in DONE SHALL abort immediately with no done pulse.

Structure
REQ-033 Shared package spike_enc_pkg SHALL hold the state enum, RATE_W default, and CNT_W=8.
REQ-034 Sub-module phase_accumulator (acc register, adder, carry output, clear and enable inputs) SHALL hold the accumulation datapath; the FSM, handshake and counter stay in the top module.

Verification
REQ-035 Load rate 128, burst_len 0, start -> spike_out 0,1,0,1... from the first RUN edge; after 20 RUN cycles spike_cnt = 10.
REQ-036 Load rate 64, burst_len 3, start -> spikes on RUN edges 4, 8 and 12; done pulses with the third spike; busy falls; cfg_ready is low throughout RUN.
REQ-037 Load rate 255, continuous, run 600 cycles -> spike_cnt saturates at 255; stop -> IDLE and spike_out=0 on the next edge.
REQ-038 Hold ena=0 for 5 cycles mid-RUN at rate 128 -> spike_out is 0 and acc and spike_cnt hold; the spike pattern resumes in phase afterwards.
REQ-039 Assert start and stop together in IDLE -> stays IDLE; drop rst_n mid-burst -> immediate IDLE, done never asserts.
REQ-040 Load rate 0, start -> busy=1 with no spikes after 300 cycles; in continuous RUN load rate 128 -> spikes begin within 2 edges.

Source files
------------

// File: rtl/spike_enc_pkg.sv
// Shared types and constants for the spike rate encoder: FSM state encoding,
// default accumulator width and the saturating spike counter helper.
package spike_enc_pkg;

  localparam int RATE_W_DEF = 8;
  localparam int CNT_W      = 8;
  localparam int BURST_W    = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/phase_accumulator.sv
// Phase accumulator datapath: acc register plus adder; carry out of the adder
// marks a phase wrap and is what the encoder turns into a spike.
module phase_accumulator #(
  parameter int RATE_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              en,
  input  logic [RATE_W-1:0] rate,
  output logic              carry
);

  logic [RATE_W-1:0] acc_q;
  logic [RATE_W-1:0] acc_d;
  logic [RATE_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + {1'b0, rate};
    acc_d = acc_q;
    if (clr) begin
      acc_d = '0;
    end else if (en) begin
      acc_d = sum[RATE_W-1:0];
    end
  end

  // Combinational carry; the caller only samples it on edges where en is high.
  assign carry = sum[RATE_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/spike_rate_encoder.sv
// Rate-coded spike generator: IDLE/RUN/DONE control around a phase accumulator,
// with a rate config handshake, optional burst length and saturating spike count.
module spike_rate_encoder
  import spike_enc_pkg::*;
#(
  parameter int RATE_W = RATE_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [RATE_W-1:0]  cfg_rate,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [BURST_W-1:0] burst_len,
  input  logic               start,
  input  logic               stop,
  output logic               spike_out,
  output logic               busy,
  output logic               done,
  output logic [CNT_W-1:0]   spike_cnt,
  output state_e             dbg_state
);

  state_e             state_q, state_d;
  logic [RATE_W-1:0]  rate_q, rate_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] burst_q, burst_d;
  logic               spike_q, spike_d;
  logic               acc_clr;
  logic               acc_en;
  logic               carry;
  logic               cfg_ready_c;
  logic [CNT_W-1:0]   cnt_inc;

  phase_accumulator #(.RATE_W(RATE_W)) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (acc_clr),
    .en    (acc_en),
    .rate  (rate_q),
    .carry (carry)
  );

  // Config handshake: rate_reg loads on any enabled edge with cfg_valid && cfg_ready;
  // a running burst locks the rate so its spike timing stays fixed.
  always_comb begin
    state_d     = state_q;
    rate_d      = rate_q;
    cnt_d       = cnt_q;
    burst_d     = burst_q;
    spike_d     = 1'b0;
    acc_clr     = 1'b0;
    acc_en      = 1'b0;
    cnt_inc     = sat_inc(cnt_q);
    cfg_ready_c = !((state_q == ST_RUN) && (burst_q != '0));

    if (ena) begin
      if (cfg_valid && cfg_ready_c) begin
        rate_d = cfg_rate;
      end
      case (state_q)
        ST_IDLE: begin
          if (start && !stop) begin
            state_d = ST_RUN;
            acc_clr = 1'b1;
            cnt_d   = '0;
            burst_d = burst_len;
          end
        end
        ST_RUN: begin
          if (stop) begin
            state_d = ST_IDLE;
          end else begin
            acc_en  = 1'b1;
            spike_d = carry;
            if (carry) begin
              cnt_d = cnt_inc;
              if ((burst_q != '0) &&
                  (cnt_inc == {{(CNT_W-BURST_W){1'b0}}, burst_q})) begin
                state_d = ST_DONE;
              end
            end
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      rate_q  <= '0;
      cnt_q   <= '0;
      burst_q <= '0;
      spike_q <= 1'b0;
    end else begin
      state_q <= state_d;
      rate_q  <= rate_d;
      cnt_q   <= cnt_d;
      burst_q <= burst_d;
      spike_q <= spike_d;
    end
  end

  assign cfg_ready = cfg_ready_c;
  assign spike_out = spike_q;
  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign spike_cnt = cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spike_rate_encoder.sv
// Directed bench for spike_rate_encoder; expected spike streams come from the
// closed form floor(k*r/2^8) - floor((k-1)*r/2^8) queued ahead of each run.
module tb_spike_rate_encoder;
  import spike_enc_pkg::*;

  localparam int RATE_W = 8;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               ena = 1'b0;
  logic [RATE_W-1:0]  cfg_rate = '0;
  logic               cfg_valid = 1'b0;
  logic               cfg_ready;
  logic [BURST_W-1:0] burst_len = '0;
  logic               start = 1'b0;
  logic               stop = 1'b0;
  logic               spike_out;
  logic               busy;
  logic               done;
  logic [CNT_W-1:0]   spike_cnt;
  state_e             dbg_state;

  int         n_checks = 0;
  int         n_errors = 0;
  int         exp_cnt = 0;
  int         n_spk;
  logic [7:0] exp_q[$];
  logic [7:0] e_m;

  always #5 clk = ~clk;

  spike_rate_encoder #(.RATE_W(RATE_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .cfg_rate  (cfg_rate),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .burst_len (burst_len),
    .start     (start),
    .stop      (stop),
    .spike_out (spike_out),
    .busy      (busy),
    .done      (done),
    .spike_cnt (spike_cnt),
    .dbg_state (dbg_state)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_rate(input logic [RATE_W-1:0] r);
    cfg_rate  = r;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic begin_run(input logic [BURST_W-1:0] bl);
    burst_len = bl;
    start     = 1'b1;
    tick();
    start     = 1'b0;
    exp_cnt   = 0;
    check("start_busy", busy, 1);
    check("start_spike", spike_out, 0);
    check("start_cnt_clr", spike_cnt, 0);
  endtask

  task automatic halt(input logic [CNT_W-1:0] cnt_hold);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stop_busy", busy, 0);
    check("stop_spike", spike_out, 0);
    check("stop_cnt_hold", spike_cnt, cnt_hold);
  endtask

  task automatic push_pattern(input int r, input int k0, input int n);
    for (int k = k0; k < k0 + n; k++) begin
      exp_q.push_back((((k * r) >> 8) != (((k - 1) * r) >> 8)) ? 8'd1 : 8'd0);
    end
  endtask

  task automatic drain(input string tag);
    logic [7:0] e;
    while (exp_q.size() > 0) begin
      tick();
      e = exp_q.pop_front();
      check(tag, spike_out, e);
      if (e == 8'd1 && exp_cnt < 255) exp_cnt++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog timeout");
  end

  initial begin
    // Reset state
    #12;
    check("rst_spike", spike_out, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_cfg_ready", cfg_ready, 1);
    check("rst_cnt", spike_cnt, 0);
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();

    // Rate 128 continuous, with a start in RUN that must be ignored
    load_rate(8'd128);
    begin_run(4'd0);
    check("a_cfg_ready", cfg_ready, 1);
    push_pattern(128, 1, 10);
    drain("a_pat");
    start = 1'b1;
    tick();
    start = 1'b0;
    check("a_start_ign_spike", spike_out, 0);
    check("a_start_ign_cnt", spike_cnt, 5);
    push_pattern(128, 12, 9);
    drain("a_pat2");
    check("a_cnt10", spike_cnt, 10);
    check("a_cnt_model", spike_cnt, exp_cnt);
    halt(8'd10);

    // Rate 64 burst of 3, with a blocked cfg attempt mid-burst
    load_rate(8'd64);
    begin_run(4'd3);
    check("b_cfg_ready_run", cfg_ready, 0);
    push_pattern(64, 1, 12);
    for (int k = 1; k <= 12; k++) begin
      if (k == 6) begin
        cfg_rate  = 8'd128;
        cfg_valid = 1'b1;
      end
      tick();
      cfg_valid = 1'b0;
      e_m = exp_q.pop_front();
      check("b_spike", spike_out, e_m);
      check("b_done", done, (k == 12));
      check("b_busy", busy, (k != 12));
      if (k < 12) check("b_cfg_ready", cfg_ready, 0);
    end
    check("b_cnt3", spike_cnt, 3);
    tick();
    check("b_done_clr", done, 0);
    check("b_spike_clr", spike_out, 0);
    check("b_idle", dbg_state, ST_IDLE);

    // Rate 255 continuous: counter saturation then stop
    load_rate(8'd255);
    begin_run(4'd0);
    repeat (600) tick();
    check("c_sat", spike_cnt, 255);
    halt(8'd255);

    // Freeze with ena=0 mid-run at rate 128; stop and cfg must be ignored
    load_rate(8'd128);
    begin_run(4'd0);
    push_pattern(128, 1, 7);
    drain("d_pre");
    ena       = 1'b0;
    cfg_rate  = 8'd0;
    cfg_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      stop = (i == 4);
      tick();
      check("d_frz_spike", spike_out, 0);
      check("d_frz_cnt", spike_cnt, 3);
      check("d_frz_busy", busy, 1);
    end
    stop      = 1'b0;
    cfg_valid = 1'b0;
    ena       = 1'b1;
    push_pattern(128, 8, 6);
    drain("d_post");
    check("d_cnt", spike_cnt, exp_cnt);
    halt(8'd6);

    // start+stop in IDLE, then reset mid-burst
    start = 1'b1;
    stop  = 1'b1;
    tick();
    start = 1'b0;
    stop  = 1'b0;
    check("e_ss_busy", busy, 0);
    check("e_ss_state", dbg_state, ST_IDLE);
    load_rate(8'd64);
    begin_run(4'd3);
    repeat (6) tick();
    check("e_mid_cnt", spike_cnt, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("e_rst_busy", busy, 0);
    check("e_rst_done", done, 0);
    check("e_rst_spike", spike_out, 0);
    check("e_rst_cnt", spike_cnt, 0);
    check("e_rst_state", dbg_state, ST_IDLE);
    repeat (3) begin
      tick();
      check("e_rst_no_done", done, 0);
    end
    rst_n = 1'b1;
    tick();

    // Rate 0 (reset value) then a live rate load in continuous RUN
    begin_run(4'd0);
    n_spk = 0;
    repeat (300) begin
      tick();
      if (spike_out !== 1'b0) n_spk++;
    end
    check("f_no_spikes", n_spk, 0);
    check("f_busy", busy, 1);
    check("f_cnt", spike_cnt, 0);
    check("f_cfg_ready", cfg_ready, 1);
    load_rate(8'd128);
    check("f_load_edge", spike_out, 0);
    tick();
    check("f_edge1", spike_out, 0);
    tick();
    check("f_edge2", spike_out, 1);
    halt(8'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
